delayed_dmem: RTL and testbench



---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_array.sv | 32 +++
 rtl/delayed_dmem.sv | 121 ++++++++++++
 tb/tb_delayed_dmem.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the multi-cycle data memory: FSM encoding, word geometry
// and the latency-counter sizing helper.
package dmem_pkg;

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] WAIT = 2'b01;
   localparam logic [1:0] DONE = 2'b10;

   localparam int WORD_BITS        = 32;
   localparam int BYTE_OFFSET_BITS = 2;

   // Counter must hold L-1 for the longer of the two latencies.
   function automatic int cnt_width(input int rd_lat, input int wr_lat);
      int longest;
      longest = (rd_lat > wr_lat) ? rd_lat : wr_lat;
      return $clog2(longest + 1);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word array: synchronous write, registered read; the read register
// only updates on load completion so rdata holds between loads.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] idx,
   input  logic [WORD_BITS-1:0]  wdata,
   output logic [WORD_BITS-1:0]  rdata
);

   logic [WORD_BITS-1:0] mem [0:(1<<DEPTH_LOG2)-1];

   // Contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (en && we)
         mem[idx] <= wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         rdata <= '0;
      else if (en && !we)
         rdata <= mem[idx];
   end

endmodule

// File: rtl/delayed_dmem.sv
// Multi-cycle data memory behind the MEM stage: accepts one access in IDLE, waits
// a configurable latency, then pulses ready while stall holds the pipeline.
module delayed_dmem
   import dmem_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10,
   parameter int RD_LATENCY = 2,
   parameter int WR_LATENCY = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req,
   input  logic                 we,
   input  logic [WORD_BITS-1:0] addr,
   input  logic [WORD_BITS-1:0] wdata,
   output logic [WORD_BITS-1:0] rdata,
   output logic                 ready,
   output logic                 stall,
   output logic                 misaligned
);

   localparam int CW = cnt_width(RD_LATENCY, WR_LATENCY);
   localparam int IW = DEPTH_LOG2;

   if (RD_LATENCY < 1) begin : g_bad_rd_latency
      $error("delayed_dmem: RD_LATENCY must be >= 1");
   end
   if (WR_LATENCY < 1) begin : g_bad_wr_latency
      $error("delayed_dmem: WR_LATENCY must be >= 1");
   end

   logic [1:0]           state;
   logic [1:0]           state_nx;
   logic [CW-1:0]        cnt;
   logic [CW-1:0]        first_cnt;
   logic                 accept;
   logic                 mem_en;

   logic                 lat_we;
   logic [IW-1:0]        lat_idx;
   logic [WORD_BITS-1:0] lat_wdata;

   logic                 acc_we;
   logic [IW-1:0]        acc_idx;
   logic [WORD_BITS-1:0] acc_wdata;

   logic                 unused_addr_bits;

   assign unused_addr_bits = ^addr[WORD_BITS-1:IW+BYTE_OFFSET_BITS];

   assign accept    = (state == IDLE) && req;
   assign first_cnt = we ? CW'(WR_LATENCY - 1) : CW'(RD_LATENCY - 1);

   // A single-cycle access enters DONE on its acceptance edge, before the latch
   // is loaded, so the array must see the live inputs in that case.
   assign acc_we    = accept ? we : lat_we;
   assign acc_idx   = accept ? addr[IW+BYTE_OFFSET_BITS-1:BYTE_OFFSET_BITS] : lat_idx;
   assign acc_wdata = accept ? wdata : lat_wdata;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (req)
               state_nx = (first_cnt == '0) ? DONE : WAIT;
         end
         WAIT: begin
            if (cnt == CW'(1))
               state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign mem_en = (state_nx == DONE) && (state != DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         lat_we    <= 1'b0;
         lat_idx   <= '0;
         lat_wdata <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            cnt       <= first_cnt;
            lat_we    <= we;
            lat_idx   <= addr[IW+BYTE_OFFSET_BITS-1:BYTE_OFFSET_BITS];
            lat_wdata <= wdata;
         end else if (state == WAIT) begin
            cnt <= cnt - CW'(1);
         end
      end
   end

   // Sticky until reset so software can poll it after the fact.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         misaligned <= 1'b0;
      else if (accept && (addr[BYTE_OFFSET_BITS-1:0] != '0))
         misaligned <= 1'b1;
   end

   assign ready = (state == DONE);
   assign stall = req & ~ready;

   dmem_array #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) u_array (
      .clk  (clk),
      .reset(reset),
      .en   (mem_en),
      .we   (acc_we),
      .idx  (acc_idx),
      .wdata(acc_wdata),
      .rdata(rdata)
   );

endmodule

// File: tb/tb_delayed_dmem.sv
// Directed bench for delayed_dmem: a table of back-to-back accesses at default
// latencies plus hand-written sequences on latency-1 and latency-4/depth-16 copies.
module tb_delayed_dmem;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          exp_lat;
      logic [31:0] exp_rdata;
   } vec_t;

   logic        clk = 1'b0;
   logic        we = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;

   logic        rst0 = 1'b1, rst1 = 1'b1, rst4 = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0, req4 = 1'b0;
   logic [31:0] rdata0, rdata1, rdata4;
   logic        ready0, ready1, ready4;
   logic        stall0, stall1, stall4;
   logic        mis0, mis1, mis4;

   int nvec = 0;
   int nmis = 0;

   always #5 clk = ~clk;

   delayed_dmem u_d0 (
      .clk(clk), .reset(rst0), .req(req0), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata0), .ready(ready0), .stall(stall0), .misaligned(mis0)
   );

   delayed_dmem #(.DEPTH_LOG2(10), .RD_LATENCY(1), .WR_LATENCY(1)) u_d1 (
      .clk(clk), .reset(rst1), .req(req1), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata1), .ready(ready1), .stall(stall1), .misaligned(mis1)
   );

   delayed_dmem #(.DEPTH_LOG2(4), .RD_LATENCY(4), .WR_LATENCY(3)) u_d4 (
      .clk(clk), .reset(rst4), .req(req4), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata4), .ready(ready4), .stall(stall4), .misaligned(mis4)
   );

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
      end
   endtask

   task automatic set_req(input int inst, input logic v);
      case (inst)
         0:       req0 = v;
         1:       req1 = v;
         default: req4 = v;
      endcase
   endtask

   task automatic get_out(input int inst, output logic rdy, output logic stl,
                          output logic [31:0] rd, output logic mis);
      case (inst)
         0:       begin rdy = ready0; stl = stall0; rd = rdata0; mis = mis0; end
         1:       begin rdy = ready1; stl = stall1; rd = rdata1; mis = mis1; end
         default: begin rdy = ready4; stl = stall4; rd = rdata4; mis = mis4; end
      endcase
   endtask

   // Starts an access at the current cycle, optionally disturbs addr/wdata during
   // the second cycle, and leaves req high so the next call runs back-to-back.
   task automatic applyStimulus(input int inst, input string name, input logic w,
                                input logic [31:0] a, input logic [31:0] d,
                                input int exp_lat, input logic [31:0] exp_rd,
                                input bit change, input logic [31:0] alt_a,
                                input logic [31:0] alt_d);
      logic        rdy, stl, mis;
      logic [31:0] rd;
      int          got_lat;
      we    = w;
      addr  = a;
      wdata = d;
      set_req(inst, 1'b1);
      got_lat = -1;
      rd      = '0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         get_out(inst, rdy, stl, rd, mis);
         if (rdy) begin
            got_lat = c;
            break;
         end
         checkOutput($sformatf("%s stall c%0d", name, c), {31'b0, stl}, 32'd1);
         if (change && c == 1) begin
            addr  = alt_a;
            wdata = alt_d;
         end
      end
      checkOutput($sformatf("%s latency", name), got_lat, exp_lat);
      checkOutput($sformatf("%s stall@ready", name), {31'b0, stl}, 32'd0);
      checkOutput($sformatf("%s rdata", name), rd, exp_rd);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle(input int inst);
      set_req(inst, 1'b0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t tbl[9];
      tbl[0] = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1, 32'h0000_0000};
      tbl[1] = '{1'b0, 32'h0000_0040, 32'h0000_0000, 2, 32'hDEAD_BEEF};
      tbl[2] = '{1'b1, 32'h0000_0044, 32'h1234_5678, 1, 32'hDEAD_BEEF};
      tbl[3] = '{1'b0, 32'h0000_0044, 32'h0000_0000, 2, 32'h1234_5678};
      tbl[4] = '{1'b1, 32'h0000_0FFC, 32'h0F0F_0F0F, 1, 32'h1234_5678};
      tbl[5] = '{1'b0, 32'h0000_0FFC, 32'h0000_0000, 2, 32'h0F0F_0F0F};
      tbl[6] = '{1'b0, 32'h0000_1040, 32'h0000_0000, 2, 32'hDEAD_BEEF};
      tbl[7] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 1, 32'hDEAD_BEEF};
      tbl[8] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 2, 32'hFFFF_FFFF};

      repeat (2) @(posedge clk);
      #1;
      rst0 = 1'b0;
      rst1 = 1'b0;
      rst4 = 1'b0;
      @(negedge clk);
      checkOutput("reset rdata", rdata0, 32'h0);
      checkOutput("reset ready", {31'b0, ready0}, 32'd0);
      checkOutput("reset misaligned", {31'b0, mis0}, 32'd0);
      @(posedge clk);
      #1;

      // Default latencies, back-to-back table
      for (int i = 0; i < 9; i++)
         applyStimulus(0, $sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata,
                       tbl[i].exp_lat, tbl[i].exp_rdata, 1'b0, '0, '0);
      idle_cycle(0);
      @(negedge clk);
      checkOutput("idle stall", {31'b0, stall0}, 32'd0);
      checkOutput("aligned misaligned", {31'b0, mis0}, 32'd0);
      @(posedge clk);
      #1;

      // Misaligned load returns the enclosing word and the flag is sticky
      applyStimulus(0, "misalign ld", 1'b0, 32'h0000_0043, '0, 2, 32'hDEAD_BEEF, 1'b0, '0, '0);
      applyStimulus(0, "after misalign", 1'b0, 32'h0000_0044, '0, 2, 32'h1234_5678, 1'b0, '0, '0);
      idle_cycle(0);
      @(negedge clk);
      checkOutput("misaligned sticky", {31'b0, mis0}, 32'd1);
      @(posedge clk);
      #1;
      rst0 = 1'b1;
      @(negedge clk);
      checkOutput("misaligned cleared", {31'b0, mis0}, 32'd0);
      checkOutput("rdata cleared", rdata0, 32'h0);
      @(posedge clk);
      #1;
      rst0 = 1'b0;

      // Single-cycle latencies
      applyStimulus(1, "l1 st", 1'b1, 32'h0000_0100, 32'h1357_9BDF, 1, 32'h0, 1'b0, '0, '0);
      applyStimulus(1, "l1 ld", 1'b0, 32'h0000_0100, '0, 1, 32'h1357_9BDF, 1'b0, '0, '0);
      idle_cycle(1);

      // Reset in the middle of a store discards it
      applyStimulus(2, "l4 st48", 1'b1, 32'h0000_0048, 32'h5A5A_5A5A, 3, 32'h0, 1'b0, '0, '0);
      applyStimulus(2, "l4 ld48", 1'b0, 32'h0000_0048, '0, 4, 32'h5A5A_5A5A, 1'b0, '0, '0);
      we    = 1'b1;
      addr  = 32'h0000_0048;
      wdata = 32'h0BAD_F00D;
      @(posedge clk);
      #1;
      rst4 = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checkOutput($sformatf("rst ready c%0d", c), {31'b0, ready4}, 32'd0);
      end
      req4 = 1'b0;
      @(posedge clk);
      #1;
      rst4 = 1'b0;
      @(negedge clk);
      checkOutput("rst rdata", rdata4, 32'h0);
      checkOutput("rst stall", {31'b0, stall4}, 32'd0);
      @(posedge clk);
      #1;
      applyStimulus(2, "post-rst ld48", 1'b0, 32'h0000_0048, '0, 4, 32'h5A5A_5A5A, 1'b0, '0, '0);

      // Depth-16 wrap: 0x40 aliases 0x00
      applyStimulus(2, "wrap st40", 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 3, 32'h5A5A_5A5A, 1'b0, '0, '0);
      applyStimulus(2, "wrap ld00", 1'b0, 32'h0000_0000, '0, 4, 32'hCAFE_F00D, 1'b0, '0, '0);

      // Inputs changed during WAIT are ignored
      applyStimulus(2, "hold st0c", 1'b1, 32'h0000_000C, 32'h1111_1111, 3, 32'hCAFE_F00D, 1'b0, '0, '0);
      applyStimulus(2, "hold st08", 1'b1, 32'h0000_0008, 32'hAAAA_5555, 3, 32'hCAFE_F00D,
                    1'b1, 32'h0000_000C, 32'h2222_2222);
      applyStimulus(2, "hold ld08", 1'b0, 32'h0000_0008, '0, 4, 32'hAAAA_5555,
                    1'b1, 32'h0000_000C, '0);
      applyStimulus(2, "hold ld0c", 1'b0, 32'h0000_000C, '0, 4, 32'h1111_1111, 1'b0, '0, '0);
      idle_cycle(2);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
